// File: rtl/md_pkg.sv
// Shared multiply/divide definitions: op encodings, latencies, FSM states.
package md_pkg;

  // E-stage md operation encodings, shared with control decode and the stall unit
  localparam logic [3:0] MD_NONE  = 4'd0;
  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MFHI  = 4'd5;
  localparam logic [3:0] MD_MFLO  = 4'd6;
  localparam logic [3:0] MD_MTHI  = 4'd7;
  localparam logic [3:0] MD_MTLO  = 4'd8;

  // Default busy latencies after an accepted start
  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  // Latency counter width; comfortably covers both latencies
  localparam int CNT_W = 8;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  // True for the four ops that start a multi-cycle operation
  function automatic logic is_start(input logic [3:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  // True for the two divide ops
  function automatic logic is_div(input logic [3:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_unit.sv
// Multiply/divide unit: computes the result at accept, holds it in pending
// registers, and commits it to HI/LO after a fixed latency.
// Handshake: a start is accepted on any edge where the state is IDLE, req is
// low and md_op is a mult/div op; busy is high from the following cycle until
// the commit edge, and the stall unit must hold further md ops off meanwhile.
module md_unit
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  md_op,
  input  logic        req,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] md_out,
  output md_state_e   dbg_state
);

  md_state_e        state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [63:0]      pend;
  logic             pend_ok;
  logic [31:0]      hi, lo;

  logic [3:0]       op_eff;
  logic             idle, start, done;

  logic [63:0]      a_sx, b_sx, prod_s, prod_u;
  logic             div_ovf, div_zero;
  logic [31:0]      b_safe, quo_s, rem_s, quo_u, rem_u;
  logic [63:0]      result;
  logic             result_ok;

  // A flush masks the op for every state update; md_out ignores req.
  assign op_eff    = req ? MD_NONE : md_op;
  assign idle      = (state == MD_IDLE);
  assign start     = idle && is_start(op_eff);
  assign done      = (state == MD_BUSY) && (cnt == CNT_W'(1));
  assign busy      = (state == MD_BUSY);
  assign dbg_state = state;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= MD_IDLE;
    else        state <= state_nxt;
  end

  // Next-state: leave IDLE on accept, return when the counter expires
  always_comb begin
    state_nxt = state;
    case (state)
      MD_IDLE: if (start) state_nxt = MD_BUSY;
      MD_BUSY: if (done)  state_nxt = MD_IDLE;
      default: state_nxt = MD_IDLE;
    endcase
  end

  // Combinational arithmetic; the divisor is forced to 1 for /0 and for the
  // INT_MIN / -1 overflow so the divider never sees an undefined case.
  always_comb begin
    a_sx      = {{32{A[31]}}, A};
    b_sx      = {{32{B[31]}}, B};
    prod_s    = $signed(a_sx) * $signed(b_sx);
    prod_u    = {32'd0, A} * {32'd0, B};
    div_zero  = (B == 32'd0);
    div_ovf   = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);
    b_safe    = (div_zero || div_ovf) ? 32'd1 : B;
    quo_s     = $signed(A) / $signed(b_safe);
    rem_s     = $signed(A) % $signed(b_safe);
    quo_u     = A / b_safe;
    rem_u     = A % b_safe;
    result    = 64'd0;
    result_ok = 1'b1;
    case (op_eff)
      MD_MULT:  result = prod_s;
      MD_MULTU: result = prod_u;
      MD_DIV:   result = div_ovf ? {32'd0, 32'h8000_0000} : {rem_s, quo_s};
      MD_DIVU:  result = {rem_u, quo_u};
      default:  result = 64'd0;
    endcase
    if (is_div(op_eff) && div_zero) result_ok = 1'b0;
  end

  // Latency counter and pending result, loaded at accept
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      pend    <= 64'd0;
      pend_ok <= 1'b0;
    end else if (start) begin
      cnt     <= is_div(op_eff) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
      pend    <= result;
      pend_ok <= result_ok;
    end else if (state == MD_BUSY) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  // HI/LO: commit at the end of the busy window, mthi/mtlo only when idle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi <= 32'd0;
      lo <= 32'd0;
    end else if (done) begin
      if (pend_ok) begin
        hi <= pend[63:32];
        lo <= pend[31:0];
      end
    end else if (idle) begin
      if (op_eff == MD_MTHI) hi <= A;
      if (op_eff == MD_MTLO) lo <= A;
    end
  end

  // Read port: purely combinational from md_op and HI/LO
  always_comb begin
    md_out = 32'd0;
    case (md_op)
      MD_MFHI: md_out = hi;
      MD_MFLO: md_out = lo;
      default: md_out = 32'd0;
    endcase
  end

endmodule
